// File: rtl/seq_bin2bcd_7seg.sv
// seq_bin2bcd_7seg
//   Sequential binary-to-BCD converter using shift-and-add-3. It consumes one input bit per
//   clock and has a seven-segment encoder for each digit. Signed input and leading-zero
//   blanking are optional. This block drives the display path for the RPN ALU result.
//
// Parameters
//   WIDTH    binary input width (>=2)
//   DIGITS   number of BCD digits; 10**DIGITS must exceed 2**WIDTH
//   BLANK_LZ 1 = digits above the most significant non-zero digit are blanked on seg_out
//
// Ports
//   clk       in  rising-edge clock
//   rst_n     in  asynchronous active-low reset
//   start     in  conversion request, taken only while busy=0
//   is_signed in  bin_in is two's complement (sampled with start)
//   bin_in    in  WIDTH-bit value to convert (sampled with start)
//   busy      out conversion in progress
//   done      out one-cycle pulse when new results are valid
//   neg       out sign of the last completed conversion
//   bcd_out   out 4*DIGITS BCD result, units digit in [3:0]
//   seg_out   out 7*DIGITS segments, digit i in [7i+6:7i], bit0=a..bit6=g, active-low
//
// Handshake: start is accepted on any rising edge where busy=0, including the cycle where done
// is high. Results appear with a done pulse WIDTH clocks later. Outputs hold their values
// until the next completion.
module seq_bin2bcd_7seg #(
   parameter int WIDTH    = 8,
   parameter int DIGITS   = 3,
   parameter int BLANK_LZ = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  is_signed,
   input  logic [WIDTH-1:0]      bin_in,
   output logic                  busy,
   output logic                  done,
   output logic                  neg,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic [7*DIGITS-1:0]   seg_out
);

   localparam int CW = $clog2(WIDTH + 1);

   // Stops at the first power of ten that is large enough, so the result cannot overflow.
   function automatic bit capacity_ok();
      longint p;
      p = 1;
      for (int i = 0; i < DIGITS; i++) begin
         p = p * 10;
         if (p > (longint'(1) << WIDTH)) return 1'b1;
      end
      return 1'b0;
   endfunction

   if (!capacity_ok()) begin : g_bad_digits
      $error("seq_bin2bcd_7seg: DIGITS too small for WIDTH");
   end

   typedef enum logic {S_IDLE, S_SHIFT} state_t;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b1000000;
         4'd1:    seg7 = 7'b1111001;
         4'd2:    seg7 = 7'b0100100;
         4'd3:    seg7 = 7'b0110000;
         4'd4:    seg7 = 7'b0011001;
         4'd5:    seg7 = 7'b0010010;
         4'd6:    seg7 = 7'b0000010;
         4'd7:    seg7 = 7'b1111000;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0010000;
         default: seg7 = 7'b1111111;
      endcase
   endfunction

   // The scan runs from the top digit down. A digit is blanked only while no non-zero digit has
   // been seen yet. Digit 0 is never blanked, so a zero result still shows "0".
   function automatic logic [7*DIGITS-1:0] encode(input logic [4*DIGITS-1:0] b);
      logic [7*DIGITS-1:0] s;
      logic                nz;
      s  = '1;
      nz = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         if (b[4*i +: 4] != 4'd0) nz = 1'b1;
         if ((BLANK_LZ != 0) && !nz && (i != 0)) s[7*i +: 7] = 7'b1111111;
         else                                    s[7*i +: 7] = seg7(b[4*i +: 4]);
      end
      return s;
   endfunction

   state_t                state_q, state_d;
   logic [WIDTH-1:0]      mag_q, mag_d;
   logic [4*DIGITS-1:0]   acc_q, acc_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  neg_pend_q, neg_pend_d;
   logic                  neg_q, neg_d;
   logic                  done_q, done_d;
   logic [4*DIGITS-1:0]   bcd_q, bcd_d;
   logic [7*DIGITS-1:0]   seg_q, seg_d;

   logic [4*DIGITS-1:0]   acc_adj;
   logic [4*DIGITS-1:0]   acc_shl;
   logic                  in_neg;

   always_comb begin
      // Add-3 correction: each digit >= 5 gets +3, with no carry between digits. Then the top
      // magnitude bit shifts into the accumulator.
      acc_adj = acc_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
      acc_shl = {acc_adj[4*DIGITS-2:0], mag_q[WIDTH-1]};
      in_neg  = is_signed & bin_in[WIDTH-1];

      state_d    = state_q;
      mag_d      = mag_q;
      acc_d      = acc_q;
      count_d    = count_q;
      neg_pend_d = neg_pend_q;
      neg_d      = neg_q;
      done_d     = 1'b0;
      bcd_d      = bcd_q;
      seg_d      = seg_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               // Negation is taken mod 2**WIDTH, so the most negative value maps to
               // 2**(WIDTH-1) as an unsigned number.
               mag_d      = in_neg ? (~bin_in + 1'b1) : bin_in;
               neg_pend_d = in_neg;
               acc_d      = '0;
               count_d    = CW'(WIDTH);
               state_d    = S_SHIFT;
            end
         end
         S_SHIFT: begin
            acc_d   = acc_shl;
            mag_d   = {mag_q[WIDTH-2:0], 1'b0};
            count_d = count_q - 1'b1;
            if (count_q == CW'(1)) begin
               bcd_d   = acc_shl;
               seg_d   = encode(acc_shl);
               neg_d   = neg_pend_q;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         mag_q      <= '0;
         acc_q      <= '0;
         count_q    <= '0;
         neg_pend_q <= 1'b0;
         neg_q      <= 1'b0;
         done_q     <= 1'b0;
         bcd_q      <= '0;
         seg_q      <= '1;
      end else begin
         state_q    <= state_d;
         mag_q      <= mag_d;
         acc_q      <= acc_d;
         count_q    <= count_d;
         neg_pend_q <= neg_pend_d;
         neg_q      <= neg_d;
         done_q     <= done_d;
         bcd_q      <= bcd_d;
         seg_q      <= seg_d;
      end
   end

   assign busy    = (state_q == S_SHIFT);
   assign done    = done_q;
   assign neg     = neg_q;
   assign bcd_out = bcd_q;
   assign seg_out = seg_q;

endmodule

// File: tb/tb_seq_bin2bcd_7seg.sv
module tb_seq_bin2bcd_7seg;

   localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                          S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                          S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                          S9 = 7'b0010000, SB = 7'b1111111;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start8, sgn8;
   logic [7:0]  bin8;
   logic        start16, sgn16;
   logic [15:0] bin16;

   logic        busy_a, done_a, neg_a;
   logic [11:0] bcd_a;
   logic [20:0] seg_a;
   logic        busy_b, done_b, neg_b;
   logic [11:0] bcd_b;
   logic [20:0] seg_b;
   logic        busy_c, done_c, neg_c;
   logic [19:0] bcd_c;
   logic [34:0] seg_c;

   int n_cmp = 0;
   int n_err = 0;
   int n;
   int pulses;

   always #5 clk = ~clk;

   seq_bin2bcd_7seg #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(0)) u_a (
      .clk(clk), .rst_n(rst_n), .start(start8), .is_signed(sgn8), .bin_in(bin8),
      .busy(busy_a), .done(done_a), .neg(neg_a), .bcd_out(bcd_a), .seg_out(seg_a));

   seq_bin2bcd_7seg #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(1)) u_b (
      .clk(clk), .rst_n(rst_n), .start(start8), .is_signed(sgn8), .bin_in(bin8),
      .busy(busy_b), .done(done_b), .neg(neg_b), .bcd_out(bcd_b), .seg_out(seg_b));

   seq_bin2bcd_7seg #(.WIDTH(16), .DIGITS(5), .BLANK_LZ(0)) u_c (
      .clk(clk), .rst_n(rst_n), .start(start16), .is_signed(sgn16), .bin_in(bin16),
      .busy(busy_c), .done(done_c), .neg(neg_c), .bcd_out(bcd_c), .seg_out(seg_c));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Launch an 8-bit conversion on both 8-bit instances. Then count clocks until done, with a
   // bound of 20.
   task automatic conv8(input logic [7:0] v, input logic s);
      start8 = 1'b1; bin8 = v; sgn8 = s;
      tick();
      start8 = 1'b0;
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (done_a) begin n = i; break; end
      end
      chk("latency8", 64'(n), 64'd8);
   endtask

   task automatic conv16(input logic [15:0] v, input logic s);
      start16 = 1'b1; bin16 = v; sgn16 = s;
      tick();
      start16 = 1'b0;
      n = 0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (done_c) begin n = i; break; end
      end
      chk("latency16", 64'(n), 64'd16);
   endtask

   initial begin
      rst_n = 1'b0; start8 = 1'b0; sgn8 = 1'b0; bin8 = '0;
      start16 = 1'b0; sgn16 = 1'b0; bin16 = '0;
      repeat (3) tick();
      chk("rst_busy", 64'(busy_a), 64'd0);
      chk("rst_done", 64'(done_a), 64'd0);
      chk("rst_neg",  64'(neg_a),  64'd0);
      chk("rst_bcd",  64'(bcd_a),  64'h0);
      chk("rst_seg",  64'(seg_a),  64'h1FFFFF);
      chk("rst_seg16", 64'(seg_c), 64'h7_FFFF_FFFF);
      rst_n = 1'b1;
      tick();

      // 255 unsigned
      start8 = 1'b1; bin8 = 8'd255; sgn8 = 1'b0;
      tick();
      start8 = 1'b0;
      chk("busy_in_shift", 64'(busy_a), 64'd1);
      chk("hold_in_shift", 64'(bcd_a), 64'h0);
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (done_a) begin n = i; break; end
      end
      chk("latency255", 64'(n), 64'd8);
      chk("bcd255", 64'(bcd_a), 64'h255);
      chk("neg255", 64'(neg_a), 64'd0);
      chk("seg255", 64'(seg_a), 64'({S2, S5, S5}));
      tick();
      chk("done_one_cycle", 64'(done_a), 64'd0);
      chk("busy_idle", 64'(busy_a), 64'd0);

      // Signed cases
      conv8(8'h80, 1'b1);
      chk("bcd_m128", 64'(bcd_a), 64'h128);
      chk("neg_m128", 64'(neg_a), 64'd1);
      chk("seg_m128", 64'(seg_a), 64'({S1, S2, S8}));
      conv8(8'hFF, 1'b1);
      chk("bcd_m1", 64'(bcd_a), 64'h001);
      chk("neg_m1", 64'(neg_a), 64'd1);
      chk("seg_m1", 64'(seg_a), 64'({S0, S0, S1}));
      chk("segb_m1", 64'(seg_b), 64'({SB, SB, S1}));
      conv8(8'h7F, 1'b1);
      chk("bcd_p127", 64'(bcd_a), 64'h127);
      chk("neg_p127", 64'(neg_a), 64'd0);
      conv8(8'h80, 1'b0);
      chk("bcd_u128", 64'(bcd_a), 64'h128);
      chk("neg_u128", 64'(neg_a), 64'd0);

      // Blanking
      conv8(8'd7, 1'b0);
      chk("bcd_7", 64'(bcd_b), 64'h007);
      chk("segb_7", 64'(seg_b), 64'({SB, SB, S7}));
      chk("sega_7", 64'(seg_a), 64'({S0, S0, S7}));
      conv8(8'd0, 1'b1);
      chk("bcd_0", 64'(bcd_b), 64'h000);
      chk("neg_0", 64'(neg_b), 64'd0);
      chk("segb_0", 64'(seg_b), 64'({SB, SB, S0}));
      conv8(8'd105, 1'b0);
      chk("segb_105", 64'(seg_b), 64'({S1, S0, S5}));
      conv8(8'd46, 1'b0);
      chk("segb_46", 64'(seg_b), 64'({SB, S4, S6}));
      conv8(8'd139, 1'b0);
      chk("seg_139", 64'(seg_a), 64'({S1, S3, S9}));

      // Start while busy is ignored
      tick();
      start8 = 1'b1; bin8 = 8'd200; sgn8 = 1'b0;
      tick();
      start8 = 1'b0; bin8 = 8'd99;
      tick();
      start8 = 1'b1; bin8 = 8'd155; sgn8 = 1'b1;
      tick();
      start8 = 1'b0;
      tick();
      start8 = 1'b1; bin8 = 8'd17;
      tick();
      start8 = 1'b0; sgn8 = 1'b0;
      pulses = 0;
      n = 0;
      for (int i = 5; i <= 20; i++) begin
         tick();
         if (done_a) begin
            pulses++;
            if (n == 0) n = i;
         end
      end
      chk("busy_ignore_lat", 64'(n), 64'd8);
      chk("busy_ignore_pulses", 64'(pulses), 64'd1);
      chk("busy_ignore_bcd", 64'(bcd_a), 64'h200);
      chk("busy_ignore_neg", 64'(neg_a), 64'd0);

      // Back-to-back: the second start lands in the done cycle of the first
      conv8(8'd33, 1'b0);
      chk("b2b_first", 64'(bcd_a), 64'h033);
      conv8(8'd250, 1'b0);
      chk("b2b_second", 64'(bcd_a), 64'h250);

      // Reset in the middle of a conversion
      tick();
      start8 = 1'b1; bin8 = 8'd99;
      tick();
      start8 = 1'b0;
      tick(); tick();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 64'(busy_a), 64'd0);
      chk("mid_rst_seg", 64'(seg_a), 64'h1FFFFF);
      chk("mid_rst_bcd", 64'(bcd_a), 64'h0);
      tick();
      rst_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done_a) pulses++;
      end
      chk("mid_rst_nodone", 64'(pulses), 64'd0);
      conv8(8'd42, 1'b0);
      chk("post_rst_bcd", 64'(bcd_a), 64'h042);
      chk("post_rst_seg", 64'(seg_a), 64'({S0, S4, S2}));

      // 16-bit instance
      conv16(16'd65535, 1'b0);
      chk("bcd_65535", 64'(bcd_c), 64'h65535);
      chk("seg_65535", 64'(seg_c), 64'({S6, S5, S5, S3, S5}));
      conv16(16'd12345, 1'b0);
      chk("bcd_12345", 64'(bcd_c), 64'h12345);
      conv16(16'h8000, 1'b1);
      chk("bcd_m32768", 64'(bcd_c), 64'h32768);
      chk("neg_m32768", 64'(neg_c), 64'd1);
      conv16(16'hFFFE, 1'b1);
      chk("bcd_m2", 64'(bcd_c), 64'h00002);
      chk("neg_m2", 64'(neg_c), 64'd1);
      conv16(16'd40960, 1'b0);
      chk("bcd_40960", 64'(bcd_c), 64'h40960);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
